// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating controller.
// Drives one ICG enable per gated domain from a REQ/ACK handshake, with a
// wake-up settle delay before ACK and an idle hysteresis before gating off.
// Lives in the always-on domain; all outputs are registered.
module clk_gate_ctrl #(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned IDLE_CYC = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_DOM-1:0] REQ,
  input  logic               FORCE_ON,
  output logic [NUM_DOM-1:0] EN,
  output logic [NUM_DOM-1:0] ACK,
  output logic               BUSY
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);

  state_e             state_q [NUM_DOM];
  state_e             state_d [NUM_DOM];
  logic [CNT_W-1:0]   cnt_q   [NUM_DOM];
  logic [CNT_W-1:0]   cnt_d   [NUM_DOM];
  logic [NUM_DOM-1:0] en_q, en_d;
  logic [NUM_DOM-1:0] ack_q, ack_d;

  // State, counter and output registers; reset drops every clock at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      en_q  <= '0;
      ack_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q  <= en_d;
      ack_q <= ack_d;
    end
  end

  // Next-state logic: identical, independent FSM per domain.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_OFF: begin
          if (REQ[i]) begin
            state_d[i] = S_WAKE;
            cnt_d[i]   = WAKE_LD;
          end
        end
        S_WAKE: begin
          // REQ is only sampled once the settle delay expires.
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end else if (REQ[i]) begin
            state_d[i] = S_ON;
          end else begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = IDLE_LD;
          end
        end
        S_ON: begin
          if (!REQ[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = IDLE_LD;
          end
        end
        S_IDLE: begin
          // Clock still running, so a re-request skips the wake delay.
          if (REQ[i]) begin
            state_d[i] = S_ON;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = S_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = S_OFF;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs move with the state.
  always_comb begin
    en_d  = '0;
    ack_d = '0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      en_d[i]  = (state_d[i] != S_OFF) | FORCE_ON;
      ack_d[i] = (state_d[i] == S_ON);
    end
  end

  assign EN   = en_q;
  assign ACK  = ack_q;
  assign BUSY = |en_q;

endmodule
